// File: rtl/mcac_cfg_arb_if.sv
// Wishbone slave bundle for the MCAC configuration bank: NUM_PORTS ports
// flattened into vectors, 32 address/data bits and 4 byte enables per port.
interface mcac_cfg_arb_if #(
   parameter int NUM_PORTS = 2
) ();
   logic [NUM_PORTS*32-1:0] i_wb_adr;
   logic [NUM_PORTS*4-1:0]  i_wb_sel;
   logic [NUM_PORTS-1:0]    i_wb_we;
   logic [NUM_PORTS*32-1:0] i_wb_dat;
   logic [NUM_PORTS*32-1:0] o_wb_dat;
   logic [NUM_PORTS-1:0]    i_wb_cyc;
   logic [NUM_PORTS-1:0]    i_wb_stb;
   logic [NUM_PORTS-1:0]    o_wb_ack;
   logic [NUM_PORTS-1:0]    o_wb_err;

   modport master (
      output i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
      input  o_wb_dat, o_wb_ack, o_wb_err
   );

   modport slave (
      input  i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat, i_wb_cyc, i_wb_stb,
      output o_wb_dat, o_wb_ack, o_wb_err
   );
endinterface

// File: rtl/mcac_cfg_arb.sv
// Byte-wide configuration register bank shared by a host strobe bus (always
// wins) and NUM_PORTS round-robin arbitrated Wishbone slave ports.
module mcac_cfg_arb #(
   parameter int NUM_PORTS = 2,
   parameter int DEPTH     = 128,
   parameter int ADDR_W    = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs,
   input  logic              rs,
   input  logic              ws,
   input  logic [ADDR_W-1:0] addrs,
   input  logic [7:0]        w_data,
   output logic [7:0]        r_data,
   mcac_cfg_arb_if.slave     wb
);
   localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int WORD_W = ADDR_W - 2;

   logic [7:0]              mem [DEPTH];
   logic                    rs_q, ws_q;
   logic                    host_wr, host_rd, host_in_range;
   logic [NUM_PORTS-1:0]    elig, ack_q, err_q;
   logic [NUM_PORTS*32-1:0] dat_q;
   logic [PTR_W-1:0]        ptr, ptr_nxt, gnt, idx;
   logic                    gnt_vld;
   logic [31:0]             g_adr, g_dat, g_rd_word;
   logic [3:0]              g_sel;
   logic                    g_we, g_err;
   logic [WORD_W-1:0]       g_word;

   assign host_wr       = cs & ws & ~ws_q;
   assign host_rd       = cs & rs & ~rs_q;
   assign host_in_range = int'(addrs) < DEPTH;

   assign elig = wb.i_wb_cyc & wb.i_wb_stb & ~ack_q & ~err_q;

   // Round-robin search: scanning from the far end lets the port nearest ptr win last.
   always_comb begin
      // NOTE: every variable gets a default before any conditional assignment, so no latch is inferred.
      gnt_vld = 1'b0;
      gnt     = '0;
      idx     = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         idx = PTR_W'((int'(ptr) + i) % NUM_PORTS);
         if (elig[idx]) begin
            gnt_vld = 1'b1;
            gnt     = idx;
         end
      end
      if (host_wr || host_rd) gnt_vld = 1'b0;
      ptr_nxt = PTR_W'((int'(gnt) + 1) % NUM_PORTS);
   end

   always_comb begin
      g_adr  = wb.i_wb_adr[32*int'(gnt) +: 32];
      g_dat  = wb.i_wb_dat[32*int'(gnt) +: 32];
      g_sel  = wb.i_wb_sel[4*int'(gnt) +: 4];
      g_we   = wb.i_wb_we[gnt];
      g_word = g_adr[ADDR_W-1:2];
      // Comparing the whole byte address also rejects bits above ADDR_W.
      g_err  = (g_adr >= 32'(DEPTH)) || (g_we && !mem[0][0]);
      g_rd_word = {mem[{g_word, 2'd3}], mem[{g_word, 2'd2}],
                   mem[{g_word, 2'd1}], mem[{g_word, 2'd0}]};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         // NOTE: the bank is built from flops rather than RAM because every byte must clear on reset.
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
         r_data <= 8'h00;
         dat_q  <= '0;
         ack_q  <= '0;
         err_q  <= '0;
         ptr    <= '0;
         rs_q   <= 1'b0;
         ws_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every read above seeing pre-edge state.
         rs_q  <= rs;
         ws_q  <= ws;
         ack_q <= '0;
         err_q <= '0;
         if (host_wr && host_in_range) mem[addrs] <= w_data;
         if (host_rd) r_data <= !host_in_range ? 8'h00 : (host_wr ? w_data : mem[addrs]);
         if (gnt_vld) begin
            ptr <= ptr_nxt;
            if (g_err) begin
               err_q[gnt]                  <= 1'b1;
               dat_q[32*int'(gnt) +: 32]   <= '0;
            end else begin
               ack_q[gnt] <= 1'b1;
               if (g_we) begin
                  for (int k = 0; k < 4; k++)
                     if (g_sel[k]) mem[{g_word, 2'(k)}] <= g_dat[8*k +: 8];
               end else begin
                  dat_q[32*int'(gnt) +: 32] <= g_rd_word;
               end
            end
         end
      end
   end

   assign wb.o_wb_dat = dat_q;
   assign wb.o_wb_ack = ack_q;
   assign wb.o_wb_err = err_q;
endmodule
